// File: rtl/rxn_timer_core.sv
// N-player reaction-timer engine: randomised go-delay, false-start
// disqualification, timeout, per-player ms times, winner and best time.
`timescale 1ns/1ps
module rxn_timer_core #(
    parameter int          NUM_PLAYERS  = 2,
    parameter int          CLK_HZ       = 100000000,
    parameter int          TIME_W       = 14,
    parameter int          MIN_DELAY_MS = 1000,
    parameter int          DELAY_BITS   = 11,
    parameter int          TIMEOUT_MS   = 9999,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [NUM_PLAYERS-1:0]        btn,
    output logic                          led_go,
    output logic                          busy,
    output logic [1:0]                    state,
    output logic                          done,
    output logic [2:0]                    winner,
    output logic                          winner_valid,
    output logic [NUM_PLAYERS-1:0]        false_start,
    output logic [NUM_PLAYERS*TIME_W-1:0] react_ms,
    output logic [TIME_W-1:0]             best_ms
);

    localparam int              TICK_DIV = CLK_HZ / 1000;
    localparam logic [TIME_W-1:0] TMAX   = '1;
    localparam logic [TIME_W-1:0] TOUT   = TIME_W'(TIMEOUT_MS);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ARM  = 2'b01,
        S_GO   = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_PLAYERS-1:0]  btn_q;
    logic [15:0]             lfsr_q, lfsr_d;
    logic [31:0]             tick_q, tick_d;
    logic [31:0]             ms_q, ms_d, ms_nxt;
    logic [31:0]             delay_q, delay_d;
    logic [NUM_PLAYERS-1:0]  fs_q, fs_d;
    logic [NUM_PLAYERS-1:0]  lat_q, lat_d;
    logic [TIME_W-1:0]       react_q [NUM_PLAYERS];
    logic [TIME_W-1:0]       react_d [NUM_PLAYERS];
    logic [2:0]              winner_q, winner_d;
    logic                    wv_q, wv_d;
    logic [TIME_W-1:0]       win_q, win_d;
    logic [TIME_W-1:0]       best_q, best_d;
    logic                    done_q, done_d;
    logic [NUM_PLAYERS-1:0]  press;
    logic                    tick;

    function automatic logic [TIME_W-1:0] sat(input logic [31:0] v);
        return (v > 32'(TMAX)) ? TMAX : v[TIME_W-1:0];
    endfunction

    assign press  = btn & ~btn_q;
    assign tick   = (tick_q == 32'(TICK_DIV - 1));
    assign ms_nxt = tick ? ms_q + 32'd1 : ms_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            btn_q    <= '0;
            lfsr_q   <= SEED;
            tick_q   <= '0;
            ms_q     <= '0;
            delay_q  <= '0;
            fs_q     <= '0;
            lat_q    <= '0;
            react_q  <= '{default: '0};
            winner_q <= '0;
            wv_q     <= 1'b0;
            win_q    <= '0;
            best_q   <= '1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            btn_q    <= btn;
            lfsr_q   <= lfsr_d;
            tick_q   <= tick_d;
            ms_q     <= ms_d;
            delay_q  <= delay_d;
            fs_q     <= fs_d;
            lat_q    <= lat_d;
            react_q  <= react_d;
            winner_q <= winner_d;
            wv_q     <= wv_d;
            win_q    <= win_d;
            best_q   <= best_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        delay_d  = delay_q;
        fs_d     = fs_q;
        lat_d    = lat_q;
        react_d  = react_q;
        winner_d = winner_q;
        wv_d     = wv_q;
        win_d    = win_q;
        best_d   = best_q;
        done_d   = 1'b0;
        tick_d   = tick ? '0 : tick_q + 32'd1;
        ms_d     = ms_nxt;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    delay_d  = 32'(MIN_DELAY_MS)
                             + 32'(lfsr_q[DELAY_BITS-1:0]);
                    lfsr_d   = {1'b0, lfsr_q[15:1]}
                             ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
                    fs_d     = '0;
                    lat_d    = '0;
                    react_d  = '{default: '0};
                    winner_d = '0;
                    wv_d     = 1'b0;
                    win_d    = '0;
                    state_d  = S_ARM;
                end
            end
            S_ARM: begin
                fs_d = fs_q | press;
                if (&fs_d) begin
                    wv_d    = 1'b0;
                    state_d = S_DONE;
                end else if (ms_nxt >= delay_q) begin
                    state_d = S_GO;
                end
            end
            S_GO: begin
                // Ascending scan: on a simultaneous press the lowest index wins.
                for (int i = 0; i < NUM_PLAYERS; i++) begin
                    if (press[i] && !fs_q[i] && !lat_q[i]) begin
                        react_d[i] = sat(ms_q);
                        lat_d[i]   = 1'b1;
                        if (!wv_d) begin
                            wv_d     = 1'b1;
                            winner_d = 3'(i);
                            win_d    = sat(ms_q);
                        end
                    end
                end
                if (ms_q >= 32'(TIMEOUT_MS)) begin
                    for (int i = 0; i < NUM_PLAYERS; i++) begin
                        if (!lat_d[i] && !fs_q[i]) react_d[i] = TOUT;
                    end
                    state_d = S_DONE;
                end else if (&(lat_d | fs_q)) begin
                    state_d = S_DONE;
                end
            end
            default: ;
        endcase
        if (state_d != state_q) begin
            tick_d = '0;
            ms_d   = '0;
        end
        if (state_d == S_DONE && state_q != S_DONE) begin
            done_d = 1'b1;
            if (wv_d && win_d < best_q) best_d = win_d;
        end
    end

    always_comb begin
        led_go = (state_q == S_GO);
        busy   = (state_q == S_ARM) || (state_q == S_GO);
    end

    assign state        = state_q;
    assign done         = done_q;
    assign winner       = winner_q;
    assign winner_valid = wv_q;
    assign false_start  = fs_q;
    assign best_ms      = best_q;

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_react
        assign react_ms[g*TIME_W +: TIME_W] = react_q[g];
    end

endmodule

// File: tb/tb_rxn_timer_core.sv
// Scoreboard bench for rxn_timer_core: directed rounds with
// hand-computed delays, times, winners and best-time tracking.
`timescale 1ns/1ps
module tb_rxn_timer_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  btn;
    logic        led_go, busy, done, winner_valid;
    logic [1:0]  state;
    logic [2:0]  winner;
    logic [1:0]  false_start;
    logic [27:0] react_ms;
    logic [13:0] best_ms;

    rxn_timer_core #(
        .NUM_PLAYERS (2),
        .CLK_HZ      (4000),
        .TIME_W      (14),
        .MIN_DELAY_MS(2),
        .DELAY_BITS  (2),
        .TIMEOUT_MS  (20),
        .SEED        (16'hACE1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .btn         (btn),
        .led_go      (led_go),
        .busy        (busy),
        .state       (state),
        .done        (done),
        .winner      (winner),
        .winner_valid(winner_valid),
        .false_start (false_start),
        .react_ms    (react_ms),
        .best_ms     (best_ms)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [13:0] r0;
        logic [13:0] r1;
        logic [2:0]  win;
        logic        wv;
        logic [1:0]  fs;
        logic [13:0] best;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   arm_run  = 0;
    int   arm_len  = 0;
    logic led_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (state == 2'b01) begin
            arm_run++;
        end else begin
            if (arm_run != 0) arm_len = arm_run;
            arm_run = 0;
        end
        if (led_go === 1'b1) led_seen = 1'b1;
    end

    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("react0", 32'(react_ms[13:0]), 32'(e.r0));
                chk("react1", 32'(react_ms[27:14]), 32'(e.r1));
                chk("winner_valid", 32'(winner_valid), 32'(e.wv));
                if (e.wv) chk("winner", 32'(winner), 32'(e.win));
                chk("false_start", 32'(false_start), 32'(e.fs));
                chk("best_ms", 32'(best_ms), 32'(e.best));
            end
        end
    end

    task automatic push(input int r0, input int r1, input int win,
                        input int wv, input int fs, input int best);
        exp_t e;
        e.r0   = 14'(r0);
        e.r1   = 14'(r1);
        e.win  = 3'(win);
        e.wv   = 1'(wv);
        e.fs   = 2'(fs);
        e.best = 14'(best);
        exp_q.push_back(e);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_go(input int exp_arm);
        int n = 0;
        while (state !== 2'b10 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            chk("go_timeout", 32'(state), 32'd2);
        end else begin
            #1;
            chk("arm_len", 32'(arm_len), 32'(exp_arm));
            chk("led_go", 32'(led_go), 32'd1);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (state !== 2'b11 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk("done_timeout", 32'(state), 32'd3);
        @(negedge clk);
        btn = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_led_busy_done"}, {29'd0, led_go, busy, done}, 32'd0);
        chk({tag, "_winner"}, {28'd0, winner, winner_valid}, 32'd0);
        chk({tag, "_fs"}, 32'(false_start), 32'd0);
        chk({tag, "_react"}, 32'(react_ms), 32'd0);
        chk({tag, "_best"}, 32'(best_ms), 32'h3FFF);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        btn   = 2'b00;
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b0;
        @(negedge clk);

        // Round 1: delay 3 ms, nobody presses, timeout at 20 ms.
        push(20, 20, 0, 0, 0, 16'h3FFF);
        pulse_start();
        wait_go(12);
        chk("busy_go", 32'(busy), 32'd1);
        wait_done();

        // Round 2: delay 2 ms, P1 at 5 ms, P0 at 7 ms.
        push(7, 5, 1, 1, 0, 5);
        pulse_start();
        wait_go(8);
        repeat (21) @(negedge clk);
        btn = 2'b10;
        repeat (8) @(negedge clk);
        btn = 2'b11;
        wait_done();

        // Round 3: P0 false-starts, P1 at 3 ms.
        push(0, 3, 1, 1, 1, 3);
        pulse_start();
        repeat (2) @(negedge clk);
        btn = 2'b01;
        wait_go(8);
        repeat (13) @(negedge clk);
        btn = 2'b11;
        wait_done();

        // Round 4: both false-start, round ends in ARM.
        push(0, 0, 0, 0, 3, 3);
        led_seen = 1'b0;
        pulse_start();
        repeat (2) @(negedge clk);
        btn = 2'b11;
        wait_done();
        chk("led_never_go", 32'(led_seen), 32'd0);

        // Round 5: delay 4 ms, ignored starts, simultaneous press at 4 ms.
        push(4, 4, 0, 1, 0, 3);
        pulse_start();
        repeat (3) @(negedge clk);
        pulse_start();
        wait_go(16);
        repeat (5) @(negedge clk);
        pulse_start();
        chk("start_ignored_go", 32'(state), 32'd2);
        repeat (11) @(negedge clk);
        btn = 2'b11;
        wait_done();

        // Round 6: delay 5 ms proves the LFSR did not advance; reset mid-GO.
        pulse_start();
        wait_go(20);
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        #1 chk_reset_vals("midgo");
        #1 reset = 1'b0;
        @(negedge clk);

        // LFSR reseeded: the first delay is 3 ms again.
        pulse_start();
        wait_go(12);
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        @(negedge clk);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("done_pulses", 32'(done_cnt), 32'd5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
